// File: rtl/expr_tokenizer_pkg.sv
// Shared definitions for the expression tokenizer.
//   - character codes read from the expression ROM
//   - operator encoding carried on the token stream
//   - error cause codes reported on err_code
//   - FSM state type and state constants
package calc_pkg;

  localparam logic [7:0] DIGIT_MAX = 8'd9;
  localparam logic [7:0] CODE_END  = 8'd10;
  localparam logic [7:0] CODE_ADD  = 8'd20;
  localparam logic [7:0] CODE_SUB  = 8'd21;
  localparam logic [7:0] CODE_MUL  = 8'd22;
  localparam logic [7:0] CODE_DIV  = 8'd23;

  // The low two bits of CODE_ADD..CODE_DIV equal the operator code.
  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_DIV = 2'd3
  } op_e;

  localparam logic [2:0] ERR_NONE    = 3'd0;
  localparam logic [2:0] ERR_OP      = 3'd1;
  localparam logic [2:0] ERR_EMPTY   = 3'd2;
  localparam logic [2:0] ERR_ILLEGAL = 3'd3;
  localparam logic [2:0] ERR_OVF     = 3'd4;
  localparam logic [2:0] ERR_NOTERM  = 3'd5;

  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE     = 3'd0;
  localparam state_t ST_SCAN     = 3'd1;
  localparam state_t ST_EMIT_NUM = 3'd2;
  localparam state_t ST_EMIT_OP  = 3'd3;
  localparam state_t ST_DONE     = 3'd4;
  localparam state_t ST_ERR      = 3'd5;

  function automatic logic is_op_code(input logic [7:0] c);
    return (c >= CODE_ADD) && (c <= CODE_DIV);
  endfunction

endpackage

// File: rtl/expr_tokenizer_if.sv
// Token stream between the tokenizer and the calculator core.
// Handshake: a token transfers on a rising edge where tok_valid && tok_ready.
// Once tok_valid is raised it stays high, and every tok_* payload signal is
// held stable, until that transfer happens. tok_ready may change freely.
//   master : tokenizer (drives valid and payload, samples ready)
//   slave  : consumer  (drives ready, samples valid and payload)
interface expr_tokenizer_if #(
  parameter int DATA_W = 16
);
  logic              tok_valid;
  logic              tok_ready;
  logic              tok_is_op;
  logic [DATA_W-1:0] tok_value;
  logic [1:0]        tok_op;
  logic              tok_last;

  modport master (
    output tok_valid, tok_is_op, tok_value, tok_op, tok_last,
    input  tok_ready
  );

  modport slave (
    input  tok_valid, tok_is_op, tok_value, tok_op, tok_last,
    output tok_ready
  );
endinterface

// File: rtl/expr_tokenizer_dec_accum.sv
// Decimal accumulate step: sum_o = acc_i*10 + digit_i.
// Optional feature macro: TOKENIZER_SAT_EN
//   defined   : a result above 2^DATA_W-1 saturates to all ones, ovf_o = 0
//   undefined : the result wraps and ovf_o flags the overflow
// Ports:
//   acc_i   current accumulator
//   digit_i decimal digit 0..9
//   sum_o   accumulated value
//   ovf_o   result did not fit in DATA_W bits
module dec_accum #(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] acc_i,
  input  logic [3:0]        digit_i,
  output logic [DATA_W-1:0] sum_o,
  output logic              ovf_o
);
  // Four extra bits hold the largest case (2^DATA_W-1)*10+9 exactly.
  logic [DATA_W+3:0] wide;
  logic              wide_ovf;

  always_comb begin
    wide     = ({4'b0000, acc_i} << 3) + ({4'b0000, acc_i} << 1)
             + {{DATA_W{1'b0}}, digit_i};
    wide_ovf = |wide[DATA_W+3:DATA_W];
  end

`ifdef TOKENIZER_SAT_EN
  assign sum_o = wide_ovf ? {DATA_W{1'b1}} : wide[DATA_W-1:0];
  assign ovf_o = 1'b0;
`else
  assign sum_o = wide[DATA_W-1:0];
  assign ovf_o = wide_ovf;
`endif
endmodule

// File: rtl/expr_tokenizer.sv
// Expression tokenizer: walks the expression ROM from index 0, accumulates
// multi-digit decimal operands, emits NUM/OP tokens on a valid/ready stream
// and stops at the terminator, or halts with a sticky error code.
// Optional feature macro: TOKENIZER_SAT_EN (saturating operand accumulation,
// handled inside dec_accum).
// Ports:
//   clk, rst   clock, asynchronous active-low reset
//   start      begin a scan from index 0 (ignored while busy)
//   rom_index  registered ROM address;  rom_data  character at rom_index
//   tok        token stream (master side)
//   busy       scan in progress;  done  one-cycle pulse after the last token
//   error      sticky error flag;  err_code  error cause
//   dbg_state  current FSM state
module expr_tokenizer
  import calc_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int ROM_AW    = 7,
  parameter int ROM_DEPTH = 100
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ROM_AW-1:0] rom_index,
  input  logic [7:0]        rom_data,
  expr_tokenizer_if.master  tok,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [2:0]        err_code,
  output state_t            dbg_state
);

  localparam logic [ROM_AW-1:0] DEPTH_IDX = ROM_AW'(ROM_DEPTH);

  state_t            state_q, state_d;
  logic [ROM_AW-1:0] idx_q, idx_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [ROM_AW-1:0] dcnt_q, dcnt_d;
  op_e               op_q, op_d;
  logic              last_q, last_d;
  logic              error_q, error_d;
  logic [2:0]        code_q, code_d;

  logic [DATA_W-1:0] acc_sum;
  logic              acc_ovf;

  dec_accum #(.DATA_W(DATA_W)) u_dec_accum (
    .acc_i   (acc_q),
    .digit_i (rom_data[3:0]),
    .sum_o   (acc_sum),
    .ovf_o   (acc_ovf)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    dcnt_d  = dcnt_q;
    op_d    = op_q;
    last_d  = last_q;
    error_d = error_q;
    code_d  = code_q;

    case (state_q)
      ST_IDLE, ST_ERR: begin
        if (start) begin
          state_d = ST_SCAN;
          idx_d   = '0;
          acc_d   = '0;
          dcnt_d  = '0;
          last_d  = 1'b0;
          error_d = 1'b0;
          code_d  = ERR_NONE;
        end
      end

      ST_SCAN: begin
        // Depth check comes first: rom_data beyond the scanned range is
        // never interpreted.
        if (idx_q == DEPTH_IDX) begin
          state_d = ST_ERR;
          error_d = 1'b1;
          code_d  = ERR_NOTERM;
        end else if (rom_data <= DIGIT_MAX) begin
          if (acc_ovf) begin
            state_d = ST_ERR;
            error_d = 1'b1;
            code_d  = ERR_OVF;
          end else begin
            acc_d  = acc_sum;
            dcnt_d = dcnt_q + ROM_AW'(1);
            idx_d  = idx_q + ROM_AW'(1);
          end
        end else if (rom_data == CODE_END) begin
          if (dcnt_q == '0) begin
            state_d = ST_ERR;
            error_d = 1'b1;
            code_d  = ERR_EMPTY;
          end else begin
            state_d = ST_EMIT_NUM;
            last_d  = 1'b1;
          end
        end else if (is_op_code(rom_data)) begin
          if (dcnt_q == '0) begin
            state_d = ST_ERR;
            error_d = 1'b1;
            code_d  = ERR_OP;
          end else begin
            state_d = ST_EMIT_NUM;
            last_d  = 1'b0;
            op_d    = op_e'(rom_data[1:0]);
          end
        end else begin
          state_d = ST_ERR;
          error_d = 1'b1;
          code_d  = ERR_ILLEGAL;
        end
      end

      ST_EMIT_NUM: begin
        if (tok.tok_ready) state_d = last_q ? ST_DONE : ST_EMIT_OP;
      end

      // The operator's index step happens on the OP transfer, so it costs
      // no extra cycle.
      ST_EMIT_OP: begin
        if (tok.tok_ready) begin
          state_d = ST_SCAN;
          acc_d   = '0;
          dcnt_d  = '0;
          idx_d   = idx_q + ROM_AW'(1);
        end
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      acc_q   <= '0;
      dcnt_q  <= '0;
      op_q    <= OP_ADD;
      last_q  <= 1'b0;
      error_q <= 1'b0;
      code_q  <= ERR_NONE;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      dcnt_q  <= dcnt_d;
      op_q    <= op_d;
      last_q  <= last_d;
      error_q <= error_d;
      code_q  <= code_d;
    end
  end

  // Token payload is decoded from registers only, so it is stable for as
  // long as the state waits for tok_ready.
  assign tok.tok_valid = (state_q == ST_EMIT_NUM) || (state_q == ST_EMIT_OP);
  assign tok.tok_is_op = (state_q == ST_EMIT_OP);
  assign tok.tok_value = (state_q == ST_EMIT_NUM) ? acc_q : '0;
  assign tok.tok_op    = (state_q == ST_EMIT_OP) ? op_q : 2'b00;
  assign tok.tok_last  = (state_q == ST_EMIT_NUM) && last_q;

  assign rom_index = idx_q;
  assign busy      = (state_q == ST_SCAN) || (state_q == ST_EMIT_NUM) ||
                     (state_q == ST_EMIT_OP);
  assign done      = (state_q == ST_DONE);
  assign error     = error_q;
  assign err_code  = code_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_expr_tokenizer.sv
module tb_expr_tokenizer;
  import calc_pkg::*;

  localparam int W = 20;  // {is_op, last, op[1:0], value[15:0]}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic       start = 1'b0;
  logic [6:0] rom_index;
  logic [7:0] rom_data;
  logic       busy, done, error;
  logic [2:0] err_code;
  state_t     dbg_state;

  expr_tokenizer_if #(.DATA_W(16)) tok_if ();

  expr_tokenizer #(.DATA_W(16), .ROM_AW(7), .ROM_DEPTH(100)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .rom_index (rom_index),
    .rom_data  (rom_data),
    .tok       (tok_if),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .err_code  (err_code),
    .dbg_state (dbg_state)
  );

  logic [7:0] rom_mem [128];
  logic [7:0] rom_init [$];
  assign rom_data = rom_mem[rom_index];

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q [$];
  int           exp_err;
  int           exp_idx;
  int           checks = 0;
  int           errors = 0;
  int           ready_mode = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] tok_word(input bit is_op, input bit last,
                                             input logic [1:0] op, input logic [15:0] v);
    return {is_op, last, op, v};
  endfunction

  // ---------------- reference model ----------------
  // Reads the ROM as an expression: numbers are decimal digit runs, checked
  // against 16-bit range, separated by operators, ended by '#'.
  task automatic model_run();
    int p, val, nd, c;
    bit fin, sat;
    sat = 1'b0;
`ifdef TOKENIZER_SAT_EN
    sat = 1'b1;
`endif
    p = 0; val = 0; nd = 0; exp_err = 0; fin = 1'b0;
    while (!fin) begin
      if (p == 100) begin
        exp_err = 5; fin = 1'b1;
      end else begin
        c = int'(rom_mem[p]);
        if (c <= 9) begin
          val = val * 10 + c;
          if (val > 65535) begin
            if (sat) val = 65535;
            else begin exp_err = 4; fin = 1'b1; end
          end
          if (!fin) begin nd++; p++; end
        end else if (c == 10) begin
          if (nd == 0) exp_err = 2;
          else exp_q.push_back(tok_word(1'b0, 1'b1, 2'd0, val[15:0]));
          fin = 1'b1;
        end else if (c >= 20 && c <= 23) begin
          if (nd == 0) begin
            exp_err = 1; fin = 1'b1;
          end else begin
            exp_q.push_back(tok_word(1'b0, 1'b0, 2'd0, val[15:0]));
            exp_q.push_back(tok_word(1'b1, 1'b0, 2'(c - 20), 16'd0));
            val = 0; nd = 0; p++;
          end
        end else begin
          exp_err = 3; fin = 1'b1;
        end
      end
    end
    exp_idx = p;
  endtask

  task automatic load_rom(input logic [7:0] fill);
    foreach (rom_mem[i]) rom_mem[i] = fill;
    foreach (rom_init[i]) rom_mem[i] = rom_init[i];
  endtask

  // ---------------- monitor ----------------
  // Every cycle a token is offered, it must equal the queue head; the head
  // is retired on the cycle it transfers.
  initial begin
    logic [W-1:0] act;
    forever begin
      @(negedge clk);
      if (rst && tok_if.tok_valid) begin
        act = {tok_if.tok_is_op, tok_if.tok_last, tok_if.tok_op, tok_if.tok_value};
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_token: got 0x%0h required no token", act);
        end else begin
          if (tok_if.tok_ready) begin
            check("token", 32'(act), 32'(exp_q[0]));
            void'(exp_q.pop_front());
          end else begin
            check("token_held", 32'(act), 32'(exp_q[0]));
          end
        end
      end
    end
  end

  // ---------------- ready driver ----------------
  // 0: always ready, 1: random, 2: 3 stall cycles per token,
  // 3: accept numbers only (stalls the first operator)
  initial begin
    int stall = 0;
    tok_if.tok_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0: tok_if.tok_ready = 1'b1;
        1: tok_if.tok_ready = 1'($urandom_range(0, 1));
        2: begin
          if (!tok_if.tok_valid) begin
            tok_if.tok_ready = 1'b0; stall = 0;
          end else if (stall < 3) begin
            tok_if.tok_ready = 1'b0; stall++;
          end else begin
            tok_if.tok_ready = 1'b1; stall = 0;
          end
        end
        default: tok_if.tok_ready = tok_if.tok_valid && !tok_if.tok_is_op;
      endcase
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_tok_valid"}, 32'(tok_if.tok_valid), 0);
    check({tag, "_tok_is_op"}, 32'(tok_if.tok_is_op), 0);
    check({tag, "_tok_value"}, 32'(tok_if.tok_value), 0);
    check({tag, "_tok_op"},    32'(tok_if.tok_op), 0);
    check({tag, "_tok_last"},  32'(tok_if.tok_last), 0);
    check({tag, "_rom_index"}, 32'(rom_index), 0);
    check({tag, "_busy"},      32'(busy), 0);
    check({tag, "_done"},      32'(done), 0);
    check({tag, "_error"},     32'(error), 0);
    check({tag, "_err_code"},  32'(err_code), 0);
  endtask

  task automatic run_scan(input string name, input int mode, input int exp_lat);
    int cyc;
    bit fin;
    ready_mode = mode;
    model_run();
    pulse_start();
    @(negedge clk);
    check({name, "_busy"}, 32'(busy), 1);
    if (exp_lat > 0) begin
      cyc = 0;
      while (!tok_if.tok_valid && cyc < 50) begin
        @(negedge clk); cyc++;
      end
      check({name, "_latency"}, 32'(cyc), 32'(exp_lat));
    end
    cyc = 0; fin = 1'b0;
    while (!fin && cyc < 2000) begin
      if (done || (error && !busy)) fin = 1'b1;
      else begin @(negedge clk); cyc++; end
    end
    if (!fin) begin
      checks++; errors++;
      $display("FAIL %s_timeout: got no end of scan required done or error", name);
      exp_q.delete();
    end else begin
      check({name, "_done"},      32'(done), (exp_err == 0) ? 1 : 0);
      check({name, "_error"},     32'(error), (exp_err == 0) ? 0 : 1);
      check({name, "_err_code"},  32'(err_code), 32'(exp_err));
      check({name, "_rom_index"}, 32'(rom_index), 32'(exp_idx));
      check({name, "_tokens_left"}, 32'(exp_q.size()), 0);
      exp_q.delete();
      @(negedge clk);
      check({name, "_done_end"}, 32'(done), 0);
      check({name, "_busy_end"}, 32'(busy), 0);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cyc, pos;
    #3;
    check_all_zero("reset");
    @(negedge clk); rst = 1'b1;

    rom_init = '{8'd5, 8'd5, 8'd21, 8'd1, 8'd10};
    load_rom(8'd30);
    run_scan("basic", 0, 3);
    run_scan("stalled", 2, 0);

    rom_init = '{8'd20, 8'd3, 8'd10};       load_rom(8'd30); run_scan("lead_op", 0, 0);
    rom_init = '{8'd4, 8'd20, 8'd10};       load_rom(8'd30); run_scan("empty", 0, 0);
    rom_init = '{8'd6, 8'd5, 8'd5, 8'd3, 8'd6, 8'd10};
    load_rom(8'd30); run_scan("overflow", 0, 0);
    rom_init = '{8'd6, 8'd5, 8'd5, 8'd3, 8'd5, 8'd10};
    load_rom(8'd30); run_scan("max_value", 1, 0);
    rom_init = '{8'd7, 8'd99, 8'd10};       load_rom(8'd30); run_scan("illegal", 0, 0);

    rom_init.delete();
    load_rom(8'd10);
    for (int i = 0; i < 100; i++) rom_mem[i] = (i % 2 == 0) ? 8'd1 : 8'd20;
    run_scan("noterm", 0, 0);

    // Random expressions, occasionally malformed.
    for (int n = 0; n < 40; n++) begin
      int nops, nd;
      foreach (rom_mem[i]) rom_mem[i] = 8'($urandom_range(0, 255));
      pos = 0;
      nops = $urandom_range(1, 4);
      for (int k = 0; k < nops; k++) begin
        nd = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 5);
        for (int d = 0; d < nd; d++) begin rom_mem[pos] = 8'($urandom_range(0, 9)); pos++; end
        rom_mem[pos] = (k == nops - 1) ? 8'd10 : 8'($urandom_range(20, 23));
        pos++;
      end
      if ($urandom_range(0, 7) == 0) rom_mem[$urandom_range(0, pos - 1)] = 8'($urandom_range(0, 255));
      run_scan("random", 1, 0);
    end

    // Asynchronous reset while an operator token is stalled.
    rom_init = '{8'd5, 8'd5, 8'd21, 8'd1, 8'd10};
    load_rom(8'd30);
    ready_mode = 3;
    model_run();
    pulse_start();
    cyc = 0;
    while (!(tok_if.tok_valid && tok_if.tok_is_op) && cyc < 50) begin
      @(negedge clk); cyc++;
    end
    check("op_stall_reached", 32'(tok_if.tok_valid && tok_if.tok_is_op), 1);
    #2 rst = 1'b0;
    #1 check_all_zero("midscan_reset");
    exp_q.delete();
    @(negedge clk); #2 rst = 1'b1;
    rom_mem[0] = 8'd7;
    run_scan("rescan", 0, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/expr_tokenizer.md
Name: expr_tokenizer

Overview:
- Sequential front-end that walks the expression ROM by index and turns its character codes into operand and operator tokens.
- Sits directly downstream of the expression ROM; drives the ROM's address and consumes its combinational data output.
- Feeds the calculator core through a valid/ready token stream.
- Accumulates multi-digit decimal numbers, checks syntax, and stops at the terminator code.

Parameters:
- DATA_W, 16, operand width in bits (unsigned).
- ROM_AW, 7, ROM index width.
- ROM_DEPTH, 100, number of ROM entries scanned before a missing terminator is declared.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  begin a scan from index 0; ignored while busy.
- rom_index  out  ROM_AW  ROM address, registered.
- rom_data  in  8  ROM character at rom_index, valid in the same cycle.
- tok_valid  out  1  token available.
- tok_ready  in  1  consumer accepts the token.
- tok_is_op  out  1  1 = operator token, 0 = number token.
- tok_value  out  DATA_W  number value (0 for operator tokens).
- tok_op  out  2  operator code: 0 add, 1 sub, 2 mul, 3 div.
- tok_last  out  1  final token of the expression.
- busy  out  1  scan in progress.
- done  out  1  one-cycle pulse after the last token transfers.
- error  out  1  sticky syntax/overflow error.
- err_code  out  3  error cause, held with error.

Behaviour:
- Character codes:
  - 0..9: decimal digits.
  - 10: terminator '#'.
  - 20 '+', 21 '-', 22 '*', 23 '/'.
  - Any other code is illegal.
- Reset (rst low, asynchronous):
  - state IDLE.
  - rom_index, tok_* outputs, accumulator, digit count: all 0.
  - busy, done, error, err_code: all 0.
  - Reset mid-scan abandons the scan; no partial token is emitted.
- States: IDLE, SCAN, EMIT_NUM, EMIT_OP, DONE, ERR.
- IDLE:
  - start=1 sets rom_index=0, acc=0, dcnt=0, clears error/err_code, goes to SCAN.
  - busy=1 from the next cycle.
- SCAN, one ROM character per cycle:
  - Digit: acc <= acc*10 + digit; dcnt++; rom_index++.
    - If the result exceeds 2^DATA_W-1: go to ERR, code 4.
  - Operator:
    - dcnt==0: go to ERR, code 1 (leading or doubled operator).
    - Otherwise latch op; go to EMIT_NUM with tok_last=0.
  - '#':
    - dcnt==0: go to ERR, code 2 (empty operand).
    - Otherwise go to EMIT_NUM with tok_last=1.
  - Illegal code: go to ERR, code 3.
  - rom_index reaches ROM_DEPTH without '#': go to ERR, code 5.
- EMIT_NUM:
  - tok_valid=1, tok_is_op=0, tok_value=acc.
  - On tok_valid && tok_ready: go to EMIT_OP (if not last) or DONE (if last).
- EMIT_OP:
  - tok_valid=1, tok_is_op=1, tok_op=latched op, tok_value=0.
  - On transfer: acc=0, dcnt=0, rom_index++, go to SCAN.
- Handshake rules:
  - While tok_valid=1 and tok_ready=0, all tok_* outputs are held stable.
  - tok_valid never drops without a transfer.
- Latency:
  - For an operand of N characters including its delimiter, tok_valid rises on the Nth rising edge after the edge that samples start.
  - Back-to-back tokens when tok_ready is held high: one token per cycle for number then operator. The operator step's index increment adds no cycle.
- DONE: done=1 for exactly one cycle, busy=0, then IDLE.
- ERR:
  - busy=0, tok_valid=0.
  - error and err_code held until the next start or reset.
  - start in ERR behaves as in IDLE.
- Simultaneous events: start while busy is ignored. Reset has priority over everything.

Optional Feature:
- Macro: TOKENIZER_SAT_EN.
- Defined: accumulator overflow saturates to 2^DATA_W-1; scanning continues and no code-4 error is raised.
- Undefined: overflow goes to ERR, code 4.

Decomposition:
- Shared package (calc_pkg):
  - character code constants: DIGIT_MAX=9, CODE_END=10, CODE_ADD..CODE_DIV=20..23.
  - operator enum, 2-bit.
  - error code constants ERR_OP=1, ERR_EMPTY=2, ERR_ILLEGAL=3, ERR_OVF=4, ERR_NOTERM=5.
  - FSM state typedef.
- One natural sub-module: dec_accum.
  - Implements the acc*10+digit multiply-add with overflow detect.
  - Implements saturation under TOKENIZER_SAT_EN.

Test Plan:
- ROM {5,5,21,1,10}, tok_ready=1, pulse start → tokens NUM 55, OP sub(1), NUM 1 with tok_last=1, then done pulse; rom_index stops at 4.
- Same ROM, tok_ready low for 3 cycles at each token → each token's payload held stable; total token count and values unchanged.
- ROM {20,3,10} → error=1, err_code=1, no tokens. ROM {4,20,10} → err_code=2 after NUM 4 is transferred.
- ROM {6,5,5,3,6,10}, DATA_W=16 → err_code=4 without the macro; with TOKENIZER_SAT_EN, NUM 65535 with last=1.
- ROM {7,99,...} → err_code=3. ROM with no 10 in entries 0..99 → err_code=5 at rom_index 100.
- rst low asynchronously while EMIT_OP is stalled → all outputs 0 immediately; a new start rescans cleanly from index 0.
